// File: rtl/lc3_writeback_cc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_writeback_cc_if: result channel from the ALU/adder stage        |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
interface lc3_writeback_cc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_dr;
  logic             in_ld_reg;
  logic             in_ld_cc;

  modport master (
    output in_valid, in_data, in_dr, in_ld_reg, in_ld_cc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_dr, in_ld_reg, in_ld_cc,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/lc3_writeback_cc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lc3_writeback_cc: LC-3 writeback stage, 8x16 register file + NZP   |
// | Optional macro WB_BYPASS_EN forwards pending/ext writes to reads.   |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module lc3_writeback_cc #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  lc3_writeback_cc_if.slave     res,
  input  wire logic             ext_we,
  input  wire logic [2:0]       ext_dr,
  input  wire logic [WIDTH-1:0] ext_data,
  input  wire logic             ext_ld_cc,
  input  wire logic [2:0]       sr1_addr,
  output logic      [WIDTH-1:0] sr1_data,
  input  wire logic [2:0]       sr2_addr,
  output logic      [WIDTH-1:0] sr2_data,
  output logic      [2:0]       nzp,
  output logic                  pend_valid
);

  localparam logic [2:0] c_nzp_n = 3'b100;
  localparam logic [2:0] c_nzp_z = 3'b010;
  localparam logic [2:0] c_nzp_p = 3'b001;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [2:0]       nzp_q, nzp_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]       s1_dr_q, s1_dr_d;
  logic             s1_ld_reg_q, s1_ld_reg_d;
  logic             s1_ld_cc_q, s1_ld_cc_d;

  logic w_commit;
  logic w_accept;

  function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])   return c_nzp_n;
    else if (v == '0) return c_nzp_z;
    else              return c_nzp_p;
  endfunction

  // ext_we owns the single write port; the pending entry waits behind it.
  assign w_commit     = s1_valid_q && !ext_we;
  assign res.in_ready = !s1_valid_q || w_commit;
  assign w_accept     = res.in_valid && res.in_ready;

  always_comb begin
    regs_d      = regs_q;
    nzp_d       = nzp_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_dr_d     = s1_dr_q;
    s1_ld_reg_d = s1_ld_reg_q;
    s1_ld_cc_d  = s1_ld_cc_q;

    if (ext_we) begin
      regs_d[ext_dr] = ext_data;
      if (ext_ld_cc) nzp_d = cc_of(ext_data);
    end else if (s1_valid_q) begin
      if (s1_ld_reg_q) regs_d[s1_dr_q] = s1_data_q;
      if (s1_ld_cc_q)  nzp_d = cc_of(s1_data_q);
      s1_valid_d = 1'b0;
    end

    if (w_accept) begin
      s1_valid_d  = 1'b1;
      s1_data_d   = res.in_data;
      s1_dr_d     = res.in_dr;
      s1_ld_reg_d = res.in_ld_reg;
      s1_ld_cc_d  = res.in_ld_cc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      nzp_q       <= c_nzp_z;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_dr_q     <= '0;
      s1_ld_reg_q <= 1'b0;
      s1_ld_cc_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      nzp_q       <= nzp_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_dr_q     <= s1_dr_d;
      s1_ld_reg_q <= s1_ld_reg_d;
      s1_ld_cc_q  <= s1_ld_cc_d;
    end
  end

  // The pending entry is younger than a concurrent ext write, so it wins.
  function automatic logic [WIDTH-1:0] rd_port(input logic [2:0] addr);
`ifdef WB_BYPASS_EN
    if (s1_valid_q && s1_ld_reg_q && s1_dr_q == addr) return s1_data_q;
    else if (ext_we && ext_dr == addr)                return ext_data;
    else                                              return regs_q[addr];
`else
    return regs_q[addr];
`endif
  endfunction

  assign sr1_data   = rd_port(sr1_addr);
  assign sr2_data   = rd_port(sr2_addr);
  assign nzp        = nzp_q;
  assign pend_valid = s1_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_writeback_cc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lc3_writeback_cc: directed + random bench with reference model  |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module tb_lc3_writeback_cc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_we;
  logic [2:0]  ext_dr;
  logic [15:0] ext_data;
  logic        ext_ld_cc;
  logic [2:0]  sr1_addr, sr2_addr;
  logic [15:0] sr1_data, sr2_data;
  logic [2:0]  nzp;
  logic        pend_valid;

  lc3_writeback_cc_if #(.WIDTH(16)) res_if ();

  lc3_writeback_cc #(.WIDTH(16), .NREG(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res        (res_if.slave),
    .ext_we     (ext_we),
    .ext_dr     (ext_dr),
    .ext_data   (ext_data),
    .ext_ld_cc  (ext_ld_cc),
    .sr1_addr   (sr1_addr),
    .sr1_data   (sr1_data),
    .sr2_addr   (sr2_addr),
    .sr2_data   (sr2_data),
    .nzp        (nzp),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dr;
    bit          ld_reg;
    bit          ld_cc;
  } entry_t;

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  entry_t      m_pend [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] flags(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (m_pend.size() != 0 && m_pend[0].ld_reg && m_pend[0].dr == a) return m_pend[0].data;
    if (ext_we && ext_dr == a) return ext_data;
`endif
    return m_regs[a];
  endfunction

  // One clock: drive, check against the model, advance the model, take the edge.
  task automatic cycle(input bit v, input logic [15:0] d, input logic [2:0] dr,
                       input bit lr, input bit lc, input bit ew, input logic [2:0] edr,
                       input logic [15:0] ed, input bit elc, input bit rn);
    bit ready;
    entry_t e;
    rst_n            = rn;
    res_if.in_valid  = v;
    res_if.in_data   = d;
    res_if.in_dr     = dr;
    res_if.in_ld_reg = lr;
    res_if.in_ld_cc  = lc;
    ext_we           = ew;
    ext_dr           = edr;
    ext_data         = ed;
    ext_ld_cc        = elc;
    #2;
    ready = (m_pend.size() == 0) || !ew;
    check("in_ready", res_if.in_ready, ready);
    check("pend_valid", pend_valid, m_pend.size() != 0);
    check("nzp", nzp, m_nzp);
    check("sr1", sr1_data, exp_read(sr1_addr));
    check("sr2", sr2_data, exp_read(sr2_addr));
    if (!rn) begin
      foreach (m_regs[i]) m_regs[i] = 16'd0;
      m_nzp = 3'b010;
      m_pend.delete();
    end else begin
      if (ew) begin
        m_regs[edr] = ed;
        if (elc) m_nzp = flags(ed);
      end else if (m_pend.size() != 0) begin
        e = m_pend.pop_front();
        if (e.ld_reg) m_regs[e.dr] = e.data;
        if (e.ld_cc)  m_nzp = flags(e.data);
      end
      if (v && ready) begin
        e.data = d; e.dr = dr; e.ld_reg = lr; e.ld_cc = lc;
        m_pend.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 16'h0, 3'd0, 0, 0, 0, 3'd0, 16'h0, 0, 1);
  endtask

  initial begin
    logic [2:0] saved_nzp;
    foreach (m_regs[i]) m_regs[i] = 16'hDEAD;
    m_nzp = 3'bxxx;
    sr1_addr = 3'd0;
    sr2_addr = 3'd0;
    rst_n = 1'b0;
    ext_we = 0; ext_dr = 0; ext_data = 0; ext_ld_cc = 0;
    res_if.in_valid = 0; res_if.in_data = 0; res_if.in_dr = 0;
    res_if.in_ld_reg = 0; res_if.in_ld_cc = 0;
    @(posedge clk); #1;
    foreach (m_regs[i]) m_regs[i] = 16'd0;
    m_nzp = 3'b010;
    m_pend.delete();
    cycle(0, 16'h0, 3'd0, 0, 0, 0, 3'd0, 16'h0, 0, 0);

    // Reset state across every address
    for (int i = 0; i < 8; i++) begin
      sr1_addr = 3'(i);
      sr2_addr = 3'(7 - i);
      idle();
    end
    check("rst_nzp", nzp, 3'b010);
    check("rst_ready", res_if.in_ready, 1'b1);

    // Single ALU result to R3
    sr1_addr = 3'd3; sr2_addr = 3'd0;
    cycle(1, 16'h8001, 3'd3, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    idle();
    check("r3_after", sr1_data, 16'h8001);
    check("nzp_neg", nzp, 3'b100);

    // Back-to-back zero then positive
    sr1_addr = 3'd1; sr2_addr = 3'd2;
    cycle(1, 16'h0000, 3'd1, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    cycle(1, 16'h7FFF, 3'd2, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    check("nzp_zero", nzp, 3'b010);
    idle();
    check("nzp_pos", nzp, 3'b001);
    check("r1", sr1_data, 16'h0000);
    check("r2", sr2_data, 16'h7FFF);

    // Write-port conflict on R5 with a held new result
    sr1_addr = 3'd5; sr2_addr = 3'd6;
    cycle(1, 16'h1234, 3'd5, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    cycle(1, 16'h0055, 3'd6, 1, 1, 1, 3'd5, 16'hFFFF, 1, 1);
    check("conflict_ready0", res_if.in_ready, 1'b0);
    cycle(1, 16'h0055, 3'd6, 1, 1, 1, 3'd5, 16'hFFFF, 1, 1);
    check("conflict_nzp", nzp, 3'b100);
    cycle(1, 16'h0055, 3'd6, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    check("r5_final_nzp", nzp, 3'b001);
    idle();
    check("r5_final", sr1_data, 16'h1234);
    check("r6_final", sr2_data, 16'h0055);

    // No-op result
    saved_nzp = nzp;
    cycle(1, 16'h0000, 3'd5, 0, 0, 0, 3'd0, 16'h0, 0, 1);
    check("noop_pend", pend_valid, 1'b1);
    idle();
    check("noop_retired", pend_valid, 1'b0);
    check("noop_nzp", nzp, saved_nzp);
    check("noop_r5", sr1_data, 16'h1234);

    // Reset with a pending write to R7
    sr1_addr = 3'd7;
    cycle(1, 16'h00AA, 3'd7, 1, 1, 0, 3'd0, 16'h0, 0, 1);
    cycle(0, 16'h0, 3'd0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
    check("midrst_pend", pend_valid, 1'b0);
    check("midrst_nzp", nzp, 3'b010);
    idle();
    check("midrst_r7", sr1_data, 16'h0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] rd;
      case ($urandom_range(0, 3))
        0: rd = 16'h0000;
        1: rd = 16'h8000;
        2: rd = 16'h7FFF;
        default: rd = 16'($urandom);
      endcase
      sr1_addr = 3'($urandom);
      sr2_addr = 3'($urandom);
      cycle($urandom_range(0, 9) < 6, rd, 3'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, 3'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 99) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc3_writeback_cc.md
Name: lc3_writeback_cc

Overview:
- Writeback stage directly downstream of the LC-3 ALU and address adder. Consumes each 16-bit result, writes it into the 8-entry general register file (R0-R7), and updates the NZP condition-code register.
- Provides two combinational read ports, SR1 and SR2, that feed the ALU `a`/`b` operands.
- Uses a valid/ready handshake on the result input, with a one-entry pending stage.
- A memory-load write path shares the single register-file write port and has priority over the pending stage.

Parameters:
- WIDTH, 16: data width of results and registers. Sign bit is WIDTH-1.
- NREG, 8: number of general registers. Fixed at 8; register addresses are 3 bits.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  in  1  result valid from the ALU/adder stage.
- in_ready  out  1  stage can accept a result this cycle.
- in_data  in  WIDTH  result value.
- in_dr  in  3  destination register.
- in_ld_reg  in  1  write in_data to in_dr.
- in_ld_cc  in  1  update NZP from in_data.
- ext_we  in  1  memory-load write request; takes the write port this cycle.
- ext_dr  in  3  memory-load destination.
- ext_data  in  WIDTH  memory-load value.
- ext_ld_cc  in  1  update NZP from ext_data.
- sr1_addr  in  3  read port 1 address.
- sr1_data  out  WIDTH  read port 1 data (combinational).
- sr2_addr  in  3  read port 2 address.
- sr2_data  out  WIDTH  read port 2 data (combinational).
- nzp  out  3  condition codes {N,Z,P}.
- pend_valid  out  1  pending stage occupied (for the hazard unit).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all 8 registers <= 0;
  - nzp <= 3'b010;
  - pending stage cleared, so pend_valid=0 and in_ready=1 on the next cycle.
  - Reset mid-operation discards any pending result without writing it.
- Pending stage (s1): holds {data, dr, ld_reg, ld_cc, valid}.
  - Accept: occurs when in_valid && in_ready; s1 loads at that edge.
  - commit = s1.valid && !ext_we.
  - in_ready = !s1.valid || commit. Back-to-back accepts run at 1/cycle when ext_we=0.
- Latency: result accepted at edge T is written to the register file and nzp at edge T+1 if ext_we=0 in the cycle before T+1. Otherwise it stalls one cycle per ext_we cycle.
- Write port arbitration:
  - ext_we=1: write ext_data to ext_dr; if ext_ld_cc, update nzp from ext_data. s1 holds.
  - Else if s1.valid: commit. Write s1.data to s1.dr if s1.ld_reg; update nzp if s1.ld_cc. s1.valid clears unless a new accept occurs at the same edge.
  - If in_ld_reg=0 and in_ld_cc=0, the entry is still accepted and committed as a no-op (e.g. branch/store results).
- NZP rule, applied to value v:
  - N = v[WIDTH-1];
  - Z = (v == 0);
  - P = !N && !Z.
  - Exactly one bit is set at all times, reset included. 16'h8000 gives N; 16'h7FFF gives P.
- Read ports (with WB_BYPASS_EN), priority high to low:
  1. s1.valid && s1.ld_reg && s1.dr==addr -> s1.data;
  2. ext_we && ext_dr==addr -> ext_data;
  3. register array.
  - The same rule applies independently to both ports.
  - Rationale: the s1 result is younger than any concurrent ext write, and commits after it, so the array ends consistent with the forwarded value.
- Simultaneous events:
  - Accept and commit in the same cycle: the old s1 commits while the new entry loads.
  - ext_we for the same dr as s1: ext writes first; s1 overwrites next cycle. Final value = s1.data.
- pend_valid = s1.valid (registered).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: read ports forward from s1 and ext_we as above. Operands are correct the cycle after accept.
- Undefined: sr1_data/sr2_data come from the register array only. Control must stall on pend_valid or ext_we. The pending stage and arbitration are unchanged.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 clocks.
  - Response: nzp=3'b010, pend_valid=0, in_ready=1, sr1_data=sr2_data=16'h0000 for all addresses.
- Single ALU result:
  - Stimulus: accept in_data=16'h8001, in_dr=3, ld_reg=1, ld_cc=1.
  - Response: with bypass, sr1_addr=3 reads 16'h8001 the cycle after accept. After the next edge, R3=16'h8001 and nzp=3'b100.
- Zero/positive CC:
  - Stimulus: back-to-back results 16'h0000 (dr=1) then 16'h7FFF (dr=2).
  - Response: nzp goes 3'b010 then 3'b001. in_ready stays 1. R1=0, R2=16'h7FFF.
- Write-port conflict:
  - Stimulus: s1 holds 16'h1234 for dr=5; ext_we=1 for 2 cycles with ext_dr=5, ext_data=16'hFFFF, ext_ld_cc=1.
  - Response during the ext cycles: in_ready=0 while in_valid is held with a new result. nzp=3'b100. sr1 at addr 5 reads 16'h1234.
  - Response after: R5=16'h1234 and nzp=3'b001 one cycle after ext_we drops.
- No-op result:
  - Stimulus: accept 16'h0000 with ld_reg=0, ld_cc=0.
  - Response: no register changes and nzp unchanged; entry is accepted and retires in 1 cycle.
- Reset mid-operation:
  - Stimulus: accept 16'h00AA to dr=7, then rst_n=0 at the next edge.
  - Response: R7=0, nzp=3'b010, pend_valid=0.
